// File: rtl/mem_access_unit.sv
// Load/store unit between a datapath and a single-port word memory.
// Sub-word stores go through a read-modify-write of the containing word.
module mem_access_unit #(
  parameter int MEM_WORDS = 101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respRData,
  output logic        respErr,
  output logic [31:0] address,
  output logic [31:0] dataIn,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] dataOut
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

  state_t      state, state_next;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        req_err;

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = sgn ? 32'(b) : {24'h0, b};
      2'b01:   r = sgn ? 32'(h) : {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    if (size == 2'b00)
      r[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (lane[1])
      r[31:16] = wdata[15:0];
    else
      r[15:0] = wdata[15:0];
    return r;
  endfunction

  always_comb begin
    req_err = 1'b0;
    case (reqSize)
      2'b01:   req_err = reqAddr[0];
      2'b10:   req_err = |reqAddr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ({2'b00, reqAddr[31:2]} >= MEM_LIMIT)
      req_err = 1'b1;
  end

  assign accept = reqValid & reqReady;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)               state_next = RESP;
          else if (!reqWrite)        state_next = LOAD;
          else if (reqSize == 2'b10) state_next = STORE;
          else                       state_next = RMW_RD;
        end
      end
      LOAD:    state_next = RESP;
      STORE:   state_next = RESP;
      RMW_RD:  state_next = RMW_WR;
      RMW_WR:  state_next = RESP;
      RESP:    if (respReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and handshakes are gated by reset so an abort takes effect in the same cycle
  always_comb begin
    reqReady  = (state == IDLE) && !reset;
    memRead   = ((state == LOAD) || (state == RMW_RD)) && !reset;
    memWrite  = ((state == STORE) || (state == RMW_WR)) && !reset;
    respValid = (state == RESP) && !reset;
    address   = (memRead || memWrite) ? {2'b00, addr_q[31:2]} : 32'h0;
    dataIn    = 32'h0;
    if (memWrite)
      dataIn = (state == STORE) ? wdata_q : merge_store(word_q, size_q, addr_q[1:0], wdata_q);
    respRData = respValid ? rdata_q : 32'h0;
    respErr   = respValid ? err_q : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      word_q   <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        write_q  <= reqWrite;
        size_q   <= reqSize;
        signed_q <= reqSigned;
        addr_q   <= reqAddr;
        wdata_q  <= reqWData;
        err_q    <= req_err;
        rdata_q  <= 32'h0;
      end
      if (state == LOAD && !write_q)
        rdata_q <= extract_load(dataOut, size_q, addr_q[1:0], signed_q);
      if (state == RMW_RD)
        word_q <= dataOut;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit with a word-array memory
// and an arithmetic reference model of loads, stores and error rules.
module tb_mem_access_unit;
  localparam int MEM_WORDS = 101;

  logic        clk, reset;
  logic        reqValid, reqReady, reqWrite, reqSigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWData;
  logic        respValid, respReady, respErr;
  logic [31:0] respRData, address, dataIn, dataOut;
  logic        memRead, memWrite;

  logic [31:0] mem     [0:MEM_WORDS-1];
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  logic        pl_en;
  logic [6:0]  pl_idx;
  logic [31:0] pl_val;
  logic        mon_en;
  int          tests = 0;
  int          fails = 0;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr),
    .reqWData(reqWData), .respValid(respValid), .respReady(respReady),
    .respRData(respRData), .respErr(respErr), .address(address), .dataIn(dataIn),
    .memRead(memRead), .memWrite(memWrite), .dataOut(dataOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (memWrite && address < 32'(MEM_WORDS)) mem[address[6:0]] <= dataIn;
  end

  assign dataOut = (address < 32'(MEM_WORDS)) ? mem[address[6:0]] : 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check("strobe_exclusive", {31'b0, memRead & memWrite}, 32'h0);
      if (!memRead && !memWrite) begin
        check("address_idle", address, 32'h0);
        check("datain_idle", dataIn, 32'h0);
      end
      if (!respValid) begin
        check("rdata_idle", respRData, 32'h0);
        check("err_idle", {31'b0, respErr}, 32'h0);
      end
    end
  end

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
           ((a >> 2) >= 32'(MEM_WORDS));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [31:0] a, input logic sg);
    int unsigned sh;
    logic [31:0] v;
    sh = 8 * a[1:0];
    v  = w;
    if (sz == 2'd0) begin
      v = (w >> sh) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (w >> sh) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
    int unsigned sh;
    logic [31:0] mask;
    sh = 8 * a[1:0];
    if (sz == 2'd2) return wd;
    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int hold,
                         input logic poke, output logic [31:0] got, output logic [31:0] din_seen);
    logic        e;
    int          lat, n, rd_cnt, wr_cnt;
    logic [31:0] idx, exp_rd, exp_din;
    e       = model_err(sz, a);
    idx     = a >> 2;
    lat     = e ? 1 : ((!wr || sz == 2'd2) ? 2 : 3);
    exp_rd  = 32'h0;
    exp_din = 32'h0;
    if (!e && !wr) exp_rd = model_load(ref_mem[idx], sz, a, sg);
    if (!e && wr) begin
      exp_din = model_store(ref_mem[idx], sz, a, wd);
      ref_mem[idx] = exp_din;
    end
    check("req_ready_idle", {31'b0, reqReady}, 32'h1);
    reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqSigned = sg; reqAddr = a; reqWData = wd;
    @(posedge clk); #1;
    reqValid = 1'b0; reqWData = $urandom; reqAddr = $urandom;
    n = 1; rd_cnt = 0; wr_cnt = 0; din_seen = 32'h0;
    while (1) begin
      if (memRead) begin
        rd_cnt++;
        check("read_address", address, idx);
      end
      if (memWrite) begin
        wr_cnt++;
        din_seen = dataIn;
        check("write_address", address, idx);
        check("write_data", dataIn, exp_din);
      end
      if (respValid || n >= 8) break;
      @(posedge clk); #1;
      n++;
    end
    got = respRData;
    check("resp_valid", {31'b0, respValid}, 32'h1);
    check("latency", n, lat);
    check("resp_rdata", respRData, exp_rd);
    check("resp_err", {31'b0, respErr}, {31'b0, e});
    check("read_strobes", rd_cnt, (!e && (!wr || sz != 2'd2)) ? 1 : 0);
    check("write_strobes", wr_cnt, (!e && wr) ? 1 : 0);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd2; reqAddr = 32'd0; reqWData = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      check("hold_valid", {31'b0, respValid}, 32'h1);
      check("hold_rdata", respRData, exp_rd);
      check("hold_err", {31'b0, respErr}, {31'b0, e});
      check("hold_req_ready", {31'b0, reqReady}, 32'h0);
      check("hold_no_strobe", {30'b0, memRead, memWrite}, 32'h0);
    end
    reqValid = 1'b0;
    respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
    check("after_resp_valid", {31'b0, respValid}, 32'h0);
    check("after_resp_ready", {31'b0, reqReady}, 32'h1);
    if (poke) begin
      @(posedge clk); #1;
      check("not_queued_strobe", {30'b0, memRead, memWrite}, 32'h0);
      check("not_queued_ready", {31'b0, reqReady}, 32'h1);
    end
  endtask

  initial begin
    logic [31:0] got, din, a, saved;
    logic        wr, sg;
    logic [1:0]  sz;
    reset = 1'b1; mon_en = 1'b0; pl_en = 1'b0; pl_idx = 7'd0; pl_val = 32'h0;
    reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'd0; reqSigned = 1'b0;
    reqAddr = 32'h0; reqWData = 32'h0; respReady = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < MEM_WORDS; i++) begin
      pl_en = 1'b1; pl_idx = 7'(i);
      pl_val = (i == 83) ? 32'hFFFFFF86 : (i == 80) ? 32'h00000008 : $urandom;
      ref_mem[i] = pl_val;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
    check("reset_req_ready", {31'b0, reqReady}, 32'h0);
    check("reset_resp_valid", {31'b0, respValid}, 32'h0);
    check("reset_strobes", {30'b0, memRead, memWrite}, 32'h0);
    reset = 1'b0; #1;
    check("first_cycle_ready", {31'b0, reqReady}, 32'h1);
    check("first_cycle_rdata", respRData, 32'h0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    run_req(1'b0, 2'd0, 1'b1, 32'd332, 32'h0, 0, 1'b0, got, din);
    check("lb_signed_332", got, 32'hFFFFFF86);
    run_req(1'b0, 2'd0, 1'b0, 32'd332, 32'h0, 1, 1'b0, got, din);
    check("lbu_332", got, 32'h00000086);
    run_req(1'b0, 2'd1, 1'b1, 32'd334, 32'h0, 0, 1'b0, got, din);
    check("lh_signed_334", got, 32'hFFFFFFFF);
    run_req(1'b1, 2'd0, 1'b0, 32'd321, 32'h000000AB, 0, 1'b0, got, din);
    check("sb_321_datain", din, 32'h0000AB08);
    run_req(1'b0, 2'd2, 1'b0, 32'd320, 32'h0, 0, 1'b0, got, din);
    check("lw_320", got, 32'h0000AB08);
    run_req(1'b0, 2'd1, 1'b1, 32'd333, 32'h0, 0, 1'b0, got, din);
    run_req(1'b0, 2'd2, 1'b0, 32'd404, 32'h0, 0, 1'b0, got, din);
    run_req(1'b0, 2'd2, 1'b0, 32'd332, 32'h0, 5, 1'b1, got, din);
    check("stall_load", got, 32'hFFFFFF86);

    // Reset during RMW_RD of a byte store
    saved = mem[80];
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd0; reqSigned = 1'b0;
    reqAddr = 32'd321; reqWData = 32'h000000CD;
    @(posedge clk); #1;
    reqValid = 1'b0;
    check("rmw_rd_read", {31'b0, memRead}, 32'h1);
    reset = 1'b1; #1;
    check("reset_gates_read", {30'b0, memRead, memWrite}, 32'h0);
    check("reset_gates_ready", {31'b0, reqReady}, 32'h0);
    @(posedge clk); #1;
    check("reset_no_write", {31'b0, memWrite}, 32'h0);
    reset = 1'b0; #1;
    check("ready_after_reset", {31'b0, reqReady}, 32'h1);
    check("no_resp_after_reset", {31'b0, respValid}, 32'h0);
    @(posedge clk); #1;
    check("word80_unchanged", mem[80], saved);

    // Reset during RMW_WR of a halfword store
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd1; reqAddr = 32'd322; reqWData = 32'h00001234;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    check("rmw_wr_write", {31'b0, memWrite}, 32'h1);
    reset = 1'b1; #1;
    check("reset_gates_write", {31'b0, memWrite}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; #1;
    check("ready_after_reset2", {31'b0, reqReady}, 32'h1);
    @(posedge clk); #1;
    check("word80_unchanged2", mem[80], saved);

    for (int t = 0; t < 80; t++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 104)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      run_req(wr, sz, sg, a, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), got, din);
    end

    for (int i = 0; i < MEM_WORDS; i++) check("final_memory", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
